// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed common-anode seven-segment driver
// shadowed BCD digits, leading-zero blanking, invalid-BCD flag
module bcd_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          bcd_err
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0] TC   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    tc;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zhi;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic                    any_bad;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign tc = (cnt == TC);

  // split the shadow vector into nibbles
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = sh_bcd[4*i +: 4];
    end
  end

  // zhi[k]: digit k and every higher digit are zero
  always_comb begin
    logic z;
    z   = 1'b1;
    zhi = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z      = z & (nib[i] == 4'd0);
      zhi[i] = z;
    end
  end

  // select the digit at the scan index
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_nx     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib   = nib[i];
        cur_dp    = sh_dp[i];
        cur_blank = blank_lz && (i != 0) && zhi[i];
        an_nx[i]  = 1'b0;
      end
    end
  end

  // any shadow nibble outside 0..9
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      any_bad = any_bad | (nib[i] > 4'd9);
    end
  end

  // capture display data on load
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_bcd <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_bcd <= bcd_in;
      sh_dp  <= dp_in;
    end
  end

  // refresh divider and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= (idx == LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // display outputs from previous-cycle state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      an        <= '1;
      digit_idx <= '0;
    end else begin
      seg       <= cur_blank ? SEG_OFF
                             : seg_of(cur_nib);
      dp        <= ~cur_dp;
      an        <= an_nx;
      digit_idx <= idx;
    end
  end

  // invalid-BCD flag follows the shadow digits
  always_ff @(posedge clk) begin
    if (rst) bcd_err <= 1'b0;
    else     bcd_err <= any_bad;
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed and random checks
// against a cycle-count behavioural display model
module tb_bcd_seg_scan;

  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  bcd_in;
  logic [3:0]   dp_in;
  logic         load;
  logic         blank_lz;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic [1:0]   digit_idx;
  logic         bcd_err;

  int checks = 0;
  int errors = 0;

  bcd_seg_scan #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .digit_idx(digit_idx),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  bit [6:0] segtab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F,
    7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  // model state: shadow digits and edges since release
  bit [3:0] md [N];
  bit [3:0] mdp;
  int       k;
  bit       mvalid = 1'b0;
  bit [6:0] e_seg;
  bit       e_dp;
  bit [3:0] e_an;
  bit [1:0] e_idx;
  bit       e_err;
  int       cur;
  int       hisum;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) md[j] = 4'd0;
      mdp    = 4'd0;
      k      = 0;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      e_an   = 4'hF;
      e_idx  = 2'd0;
      e_err  = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      cur   = (k / R) % N;
      hisum = 0;
      for (int j = cur; j < N; j++) hisum += md[j];
      if (blank_lz && cur != 0 && hisum == 0)
        e_seg = 7'h7F;
      else
        e_seg = segtab[md[cur]];
      e_dp  = ~mdp[cur];
      e_an  = ~(4'b0001 << cur);
      e_idx = 2'(cur);
      e_err = 1'b0;
      for (int j = 0; j < N; j++)
        if (md[j] > 9) e_err = 1'b1;
      if (load) begin
        for (int j = 0; j < N; j++)
          md[j] = bcd_in[4*j +: 4];
        mdp = dp_in;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_seg", seg, e_seg);
      chk("m_dp", dp, e_dp);
      chk("m_an", an, e_an);
      chk("m_idx", digit_idx, e_idx);
      chk("m_err", bcd_err, e_err);
    end
  end

  task automatic wait_an(input logic [3:0] a);
    int n = 0;
    while (an !== a && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an", an, a);
  endtask

  task automatic do_load(
    input logic [15:0] v,
    input logic [3:0]  d
  );
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] an_seq  [4] = '{4'h7, 4'hB, 4'hD, 4'hE};
  logic [6:0] s0050   [4] = '{7'h7F, 7'h7F, 7'h12, 7'h40};
  logic [6:0] s0000   [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
  logic [6:0] s00a7   [4] = '{7'h7F, 7'h7F, 7'h3F, 7'h78};
  logic [3:0] scan_an [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [6:0] scan_sg [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
  logic       dp_exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    blank_lz = 1'b0;
    bcd_in   = '0;
    dp_in    = '0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_err", bcd_err, 1'b0);
    chk("rst_idx", digit_idx, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_an", an, 4'hE);
    chk("rel_seg", seg, 7'h40);
    chk("rel_dp", dp, 1'b1);

    do_load(16'h1234, 4'h0);
    for (int i = 0; i < 5; i++) begin
      wait_an(scan_an[i]);
      chk("scan_seg", seg, scan_sg[i]);
    end

    blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("lz0050", seg, s0050[i]);
    end
    do_load(16'h0000, 4'h0);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("lz0000", seg, s0000[i]);
    end
    blank_lz = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("nolz", seg, 7'h40);
    end

    blank_lz = 1'b1;
    bcd_in   = 16'h00A7;
    load     = 1'b1;
    @(negedge clk);
    chk("err_pre", bcd_err, 1'b0);
    load = 1'b0;
    @(negedge clk);
    chk("err_set", bcd_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("bad_seg", seg, s00a7[i]);
    end
    bcd_in = 16'h0007;
    load   = 1'b1;
    @(negedge clk);
    chk("err_hold", bcd_err, 1'b1);
    load = 1'b0;
    @(negedge clk);
    chk("err_clr", bcd_err, 1'b0);

    wait_an(4'h7);
    wait_an(4'hE);
    repeat (2) @(negedge clk);
    bcd_in = 16'h9999;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("tc_old_an", an, 4'hE);
    chk("tc_old_seg", seg, 7'h78);
    @(negedge clk);
    chk("tc_an", an, 4'hD);
    chk("tc_seg", seg, 7'h10);
    do_load(16'h9999, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("dp_sel", dp, dp_exp[i]);
    end

    blank_lz = 1'b0;
    bcd_in   = 16'h5678;
    dp_in    = 4'h0;
    load     = 1'b1;
    @(negedge clk);
    wait_an(4'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_dp", dp, 1'b1);
    chk("mrst_idx", digit_idx, 2'd0);
    chk("mrst_err", bcd_err, 1'b0);
    rst    = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    @(negedge clk);
    chk("mrel_an", an, 4'hE);
    chk("mrel_seg", seg, 7'h40);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_seq[i]);
      chk("mrel_zero", seg, 7'h40);
    end

    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0)
        load = 1'b1;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 2) == 0)
          bcd_in[4*j +: 4] = 4'd0;
        else
          bcd_in[4*j +: 4] = 4'($urandom_range(0, 15));
      end
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0)
        blank_lz = ~blank_lz;
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed seven-segment display driver that sits directly downstream of the BCD counters. It captures a packed vector of BCD digits (one nibble per counter) and time-multiplexes them onto a common-anode display, one digit at a time. It provides optional leading-zero blanking, per-digit decimal points and invalid-BCD detection. All outputs are registered.

## Interface
- NUM_DIGITS, 4, number of BCD digits and anodes driven (2..8)
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>= 2)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- bcd_in  input  4*NUM_DIGITS  packed BCD digits; nibble 0 (bits 3:0) is least significant
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high
- load  input  1  capture strobe: bcd_in and dp_in are copied into the shadow registers on a clock edge where load=1
- blank_lz  input  1  leading-zero blanking enable (level, sampled every cycle)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  NUM_DIGITS  anode enables, active-low, one-hot-low while running
- digit_idx  output  $clog2(NUM_DIGITS)  index of the digit currently lit
- bcd_err  output  1  high while any shadow nibble is greater than 9

## Operation
- **Shadow registers.** Shadow digits and decimal points reset to 0. When load=1 they take bcd_in and dp_in. The display always shows the shadow registers, never bcd_in directly.
- **Refresh counter.** Counts 0..REFRESH_DIV-1 and then wraps. The cycle on which it reaches REFRESH_DIV-1 is the terminal count.
- **Scan index.** On terminal count the scan index increments. It wraps from NUM_DIGITS-1 to 0.
- **Decode, active-low.** The shown digit is the shadow digit at the current scan index.
  - Digits 0..9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
  - Invalid values 10..15: 3F (dash, segment g only).
  - Blanked digit: 7F.
- **Leading-zero blanking** applies only when blank_lz=1.
  - Digit k is blanked if shadow digit k and every higher digit equal 0.
  - Digit 0 is never blanked.
  - An invalid nibble counts as non-zero.
  - On a blanked digit, an is still driven for that digit and dp still follows dp_in.
- **Decimal point.** dp = ~shadow_dp[idx].
- **Error flag.** bcd_err is registered and recomputed from the captured value on every load. It is not sticky across loads.
- **Reset.** rst overrides load and scanning. A mid-operation reset immediately restores all reset values.

## Timing
- **Reset values** (all registered): seg=7F, dp=1, an=all ones, digit_idx=0, bcd_err=0, refresh counter=0, shadow registers=0.
- **First edge after rst falls:** an=~1 (digit 0 lit), seg=40, dp=1.
- **Latency:** the outputs (seg, dp, an, digit_idx) reflect the scan index and shadow registers as they were during the previous cycle.
  - A load sampled at edge N appears on seg at edge N+1.
  - bcd_err updates at edge N+1.
- **Scan advance:** a terminal count at edge N updates the scan index at N; the outputs show the new digit at N+1.
- **Digit dwell time:** each digit is held for exactly REFRESH_DIV cycles, giving a full frame of NUM_DIGITS*REFRESH_DIV cycles.
- **Simultaneous load and scan advance:** both take effect. The output at N+1 shows the new digit index with the new shadow value.
- **Handshake:** load has no handshake and no ready signal. It may be held high continuously, in which case the display tracks bcd_in with one extra cycle of delay.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- **Reset.** Hold rst=1 for 2 cycles → an=F, seg=7F, dp=1, bcd_err=0. One edge after release → an=E, seg=40.
- **Scan order.** load 1234, dp_in=0, blank_lz=0 → an steps E, D, B, 7 with seg 19, 30, 24, 79, each held 4 cycles, then wraps back to an=E.
- **Leading-zero blanking.** load 0050, blank_lz=1 → seg shows 7F, 7F, 12, 40 for digits 3..0. Then load 0000 → digits 3..1 show 7F and digit 0 shows 40. Set blank_lz=0 → all four digits show 40.
- **Invalid BCD.** load 00A7 → digit 1 shows 3F and is not blanked; bcd_err=1 one edge after the load. Then load 0007 → bcd_err=0 one edge later.
- **Load at terminal count.** Pulse load with 9999 on the terminal-count cycle of digit 0 → next edge shows an=D, seg=10. Set dp_in=0100 → dp=0 only while an=B.
- **Reset mid-scan.** While digit 2 is lit with load=1, assert rst → next edge gives reset values. After release the display shows 0000 starting from digit 0.
